// File: rtl/down_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : down_counter_pkg
//  Description : Shared types and constants for the down_counter_timer block:
//                FSM state encoding and legal PRESCALE range.
//  Revision    : 1.0  initial release
// ============================================================================
package down_counter_pkg;

  // 2-bit FSM state encodings
  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_RUN_ENC     = 2'd1;
  localparam logic [1:0] ST_EXPIRED_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_RUN     = ST_RUN_ENC,
    ST_EXPIRED = ST_EXPIRED_ENC
  } state_t;

  // Legal range for the prescaler divide ratio
  localparam int PRESCALE_MIN = 2;
  localparam int PRESCALE_MAX = 256;

  // True when a divide ratio lies in the supported range
  function automatic logic prescale_legal(input int p);
    return (p >= PRESCALE_MIN) && (p <= PRESCALE_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/down_counter_timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides enabled cycles down to one tick per PRESCALE enabled
//                cycles. The phase holds while en=0 and restarts on clr.
//                Only instantiated when DOWN_COUNTER_TIMER_PRESCALE_EN is set.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler
  import down_counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  // Counter width is ceil(log2(PRESCALE)), never narrower than one bit
  localparam int              CW   = (PRESCALE > PRESCALE_MIN) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // The tick fires on the last enabled cycle of each PRESCALE-long window
  assign tick = en && (cnt == LAST);

  // Phase counter: advances only on enabled cycles, wraps at LAST
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/down_counter_timer.sv
`default_nettype none
// ============================================================================
//  Module      : down_counter_timer
//  Description : Loadable down counter used as a programmable interval timer.
//                Emits a one-cycle terminal-count pulse (tc), a sticky done
//                flag and a busy indication; optional auto-reload.
//                Optional prescaler enabled by `DOWN_COUNTER_TIMER_PRESCALE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module down_counter_timer
  import down_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             done,
  output logic             busy
);

  state_t state;
  logic   reload_pend;   // terminal count reached with auto_reload: reload next cycle
  logic   run_en;
  logic   tick;

  // Ticks are only meaningful while counting
  assign run_en = en && (state == ST_RUN);

  // An out-of-range divide ratio is rejected at elaboration
  if (!prescale_legal(PRESCALE)) begin : g_prescale_range_check
    $error("down_counter_timer: PRESCALE outside supported range");
  end

`ifdef DOWN_COUNTER_TIMER_PRESCALE_EN
  // One tick per PRESCALE enabled cycles; load restarts the phase
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_tick_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    (run_en),
    .tick  (tick)
  );
`else
  assign tick = run_en;
`endif

  // Timer FSM with registered count, pulse, sticky done and busy outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      q           <= '0;
      tc          <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      reload_pend <= 1'b0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        // Load overrides everything, including a tick in the same cycle
        reload_pend <= 1'b0;
        q           <= load_val;
        if (load_val == '0) begin
          // Zero-length interval expires immediately
          tc    <= 1'b1;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_EXPIRED;
        end else begin
          done  <= 1'b0;
          busy  <= 1'b1;
          state <= ST_RUN;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            busy <= 1'b0;
          end

          ST_RUN: begin
            if (reload_pend) begin
              // Cycle after an auto-reload terminal count: restart the period
              reload_pend <= 1'b0;
              q           <= load_val;
              if (load_val == '0) begin
                tc    <= 1'b1;
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= ST_EXPIRED;
              end
            end else if (tick) begin
              if (q == WIDTH'(1)) begin
                q  <= '0;
                tc <= 1'b1;
                if (auto_reload) begin
                  reload_pend <= 1'b1;
                end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_EXPIRED;
                end
              end else if (q != '0) begin
                // Never wrap below zero
                q <= q - WIDTH'(1);
              end
            end
          end

          ST_EXPIRED: begin
            q    <= '0;
            busy <= 1'b0;
          end

          default: begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            reload_pend <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire
